// File: rtl/conv2d_if.sv
// conv2d_if: frame-memory read port, result write port and start/ready handshake for conv2d
interface conv2d_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
);
  logic              start;
  logic [DATA_W-1:0] d_in;
  logic [ADDR_W-1:0] ReadAddress;
  logic [ADDR_W-1:0] WriteAddress;
  logic [DATA_W-1:0] d_out;
  logic              ready;
  modport master (output start, d_in, input ReadAddress, WriteAddress, d_out, ready);
  modport slave  (input start, d_in, output ReadAddress, WriteAddress, d_out, ready);
endinterface

// File: rtl/conv2d.sv
// conv2d: 3x3 Gaussian (1-2-1) convolution over a row-major frame; define CONV2D_ZERO_PAD_EN for same-size zero-padded output
module conv2d #(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
) (
  input logic     clk,
  input logic     rst,
  conv2d_if.slave bus
);
`ifdef CONV2D_ZERO_PAD_EN
  localparam int OW = IMG_W;
  localparam int OH = IMG_H;
`else
  localparam int OW = IMG_W - 2;
  localparam int OH = IMG_H - 2;
`endif
  localparam int ACC_W = DATA_W + 5;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state;
  logic [ADDR_W-1:0] r, c, nr, nc;
  logic [1:0]        kr, kc, nkr, nkc, sh;
  logic [ACC_W-1:0]  acc, acc_sum, rnd;
  logic              tap_in, tap_last, px_last_c, frame_last;
`ifdef CONV2D_ZERO_PAD_EN
  // A tap is inside the image unless it steps off an edge from a border pixel
  function automatic logic in_img(input logic [ADDR_W-1:0] rr, cc, input logic [1:0] ir, ic);
    return !((rr == '0 && ir == 2'd0) || (rr == ADDR_W'(IMG_H - 1) && ir == 2'd2) ||
             (cc == '0 && ic == 2'd0) || (cc == ADDR_W'(IMG_W - 1) && ic == 2'd2));
  endfunction
  // Off-image taps park the read port on the centre pixel; their data is discarded
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] rr, cc, input logic [1:0] ir, ic);
    return in_img(rr, cc, ir, ic) ?
      (rr + ADDR_W'(ir) - ADDR_W'(1)) * ADDR_W'(IMG_W) + cc + ADDR_W'(ic) - ADDR_W'(1) :
      rr * ADDR_W'(IMG_W) + cc;
  endfunction
`else
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] rr, cc, input logic [1:0] ir, ic);
    return (rr + ADDR_W'(ir)) * ADDR_W'(IMG_W) + cc + ADDR_W'(ic);
  endfunction
`endif
  // Weighted tap accumulate, rounding, and next tap / next pixel positions
  always_comb begin
`ifdef CONV2D_ZERO_PAD_EN
    tap_in = in_img(r, c, kr, kc);
`else
    tap_in = 1'b1;
`endif
    sh = 2'(kr == 2'd1) + 2'(kc == 2'd1);
    acc_sum = acc + (tap_in ? ACC_W'(bus.d_in) << sh : '0);
    rnd = acc_sum + ACC_W'(8);
    tap_last = kr == 2'd2 && kc == 2'd2;
    nkc = kc == 2'd2 ? 2'd0 : kc + 2'd1;
    nkr = kc == 2'd2 ? kr + 2'd1 : kr;
    px_last_c = c == ADDR_W'(OW - 1);
    nc = px_last_c ? '0 : c + ADDR_W'(1);
    nr = px_last_c ? r + ADDR_W'(1) : r;
    frame_last = px_last_c && r == ADDR_W'(OH - 1);
  end
  // Frame FSM: one tap per clock, result registered on the ninth tap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      r <= '0;
      c <= '0;
      kr <= '0;
      kc <= '0;
      acc <= '0;
      bus.ReadAddress <= '0;
      bus.WriteAddress <= '0;
      bus.d_out <= '0;
      bus.ready <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          state <= RUN;
          bus.ready <= 1'b0;
          r <= '0;
          c <= '0;
          kr <= '0;
          kc <= '0;
          acc <= '0;
          bus.ReadAddress <= tap_addr('0, '0, 2'd0, 2'd0);
        end
        RUN: if (!tap_last) begin
          acc <= acc_sum;
          kr <= nkr;
          kc <= nkc;
          bus.ReadAddress <= tap_addr(r, c, nkr, nkc);
        end else begin
          acc <= '0;
          kr <= '0;
          kc <= '0;
          bus.d_out <= DATA_W'(rnd >> 4);
          bus.WriteAddress <= r * ADDR_W'(OW) + c;
          if (frame_last) begin
            state <= DONE;
            bus.ready <= 1'b1;
          end else begin
            r <= nr;
            c <= nc;
            bus.ReadAddress <= tap_addr(nr, nc, 2'd0, 2'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv2d.sv
// tb_conv2d: random and directed frames against a 2-D convolution reference model
module tb_conv2d;
  localparam int IMG_W = 5;
  localparam int IMG_H = 5;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;
  localparam int N_IN = IMG_W * IMG_H;
`ifdef CONV2D_ZERO_PAD_EN
  localparam int OW = IMG_W;
  localparam int OH = IMG_H;
  localparam int OFF = 0;
`else
  localparam int OW = IMG_W - 2;
  localparam int OH = IMG_H - 2;
  localparam int OFF = 1;
`endif
  localparam int N_OUT = OW * OH;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   mem [N_IN];
  int   exp_d [N_OUT];
  int   n_chk = 0;
  int   n_fail = 0;
  conv2d_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
  conv2d #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  assign bus.d_in = int'(bus.ReadAddress) < N_IN ? DATA_W'(mem[bus.ReadAddress]) : '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Reference: weighted 3x3 neighbourhood sum with zero outside the image, rounded /16
  task automatic compute_ref();
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++) begin
        int s = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            int y = r + OFF + dr;
            int x = c + OFF + dc;
            if (y >= 0 && y < IMG_H && x >= 0 && x < IMG_W)
              s += (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1) * mem[y * IMG_W + x];
          end
        exp_d[r * OW + c] = (s + 8) / 16;
      end
  endtask
  // pulse: re-assert start mid-frame; keep: leave start high throughout and after
  task automatic run_frame(input string name, input bit pulse, input bit keep);
    compute_ref();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    chk({name, " accept ready"}, 32'(bus.ready), 0);
    chk({name, " accept raddr"}, 32'(bus.ReadAddress), 0);
    if (!keep) bus.start = 1'b0;
    for (int n = 0; n < N_OUT; n++) begin
      for (int s = 1; s <= 9; s++) begin
        @(posedge clk);
        #1;
        if (pulse) bus.start = (n == 3 && s == 2);
        if (s == 4 && n > 0) begin
          chk($sformatf("%s hold d_out[%0d]", name, n - 1), 32'(bus.d_out), 32'(exp_d[n - 1]));
          chk($sformatf("%s hold waddr[%0d]", name, n - 1), 32'(bus.WriteAddress), 32'(n - 1));
        end
      end
      chk($sformatf("%s d_out[%0d]", name, n), 32'(bus.d_out), 32'(exp_d[n]));
      chk($sformatf("%s waddr[%0d]", name, n), 32'(bus.WriteAddress), 32'(n));
      chk($sformatf("%s ready[%0d]", name, n), 32'(bus.ready), 32'(n == N_OUT - 1));
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.start = 1'b0;
    foreach (mem[i]) mem[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset raddr", 32'(bus.ReadAddress), 0);
    chk("reset waddr", 32'(bus.WriteAddress), 0);
    chk("reset d_out", 32'(bus.d_out), 0);
    chk("reset ready", 32'(bus.ready), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle ready", 32'(bus.ready), 0);
    foreach (mem[i]) mem[i] = 100;
    run_frame("const", 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("done ready held", 32'(bus.ready), 1);
    chk("done d_out held", 32'(bus.d_out), 32'(exp_d[N_OUT - 1]));
    foreach (mem[i]) mem[i] = i;
    run_frame("ramp", 1'b0, 1'b0);
    foreach (mem[i]) mem[i] = 0;
    mem[N_IN / 2] = 4095;
    run_frame("impulse", 1'b0, 1'b0);
    foreach (mem[i]) mem[i] = 4095;
    run_frame("max", 1'b0, 1'b0);
    for (int t = 0; t < 3; t++) begin
      foreach (mem[i]) mem[i] = int'($urandom_range(0, 4095));
      run_frame($sformatf("rand%0d", t), t == 1, 1'b0);
    end
    foreach (mem[i]) mem[i] = int'($urandom_range(0, 4095));
    run_frame("held_a", 1'b0, 1'b1);
    foreach (mem[i]) mem[i] = int'($urandom_range(0, 4095));
    run_frame("held_b", 1'b0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort raddr", 32'(bus.ReadAddress), 0);
    chk("abort waddr", 32'(bus.WriteAddress), 0);
    chk("abort d_out", 32'(bus.d_out), 0);
    chk("abort ready", 32'(bus.ready), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort idle d_out", 32'(bus.d_out), 0);
    chk("abort idle ready", 32'(bus.ready), 0);
    foreach (mem[i]) mem[i] = int'($urandom_range(0, 4095));
    run_frame("after_abort", 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
